ps2_host_tx: RTL
================

# ps2_host_tx

Host-to-device PS/2 transmitter: it sends one command byte (LED set 0xED, enable 0xF4, reset 0xFF, and so on) from the FPGA to the keyboard over the same PS2Clk/PS2Data pair the keyboard receive path listens on. It drives both lines open-drain, generates the request-to-send sequence, and shifts the byte out on device-generated clock edges. It reports the device acknowledge bit, an acknowledge error, or a timeout. While `busy` is high, the receive path's output is ignored.

## Interface
- `INHIBIT_CYCLES`, default 10000: clock-low hold time (100 µs at 100 MHz).
- `TIMEOUT_CYCLES`, default 2000000: maximum time from releasing the clock to seeing the acknowledge (20 ms).
- `clk` in 1: system clock, 100 MHz.
- `rst_n` in 1: synchronous, active-low reset.
- `tx_data` in 8: command byte, sampled on accept.
- `tx_valid` in 1: request to send.
- `tx_ready` out 1: high only in IDLE.
- `PS2Clk_in` in 1: raw PS2Clk pin level.
- `PS2Data_in` in 1: raw PS2Data pin level.
- `ps2_clk_oe` out 1: 1 = pull PS2Clk low, 0 = release.
- `ps2_data_oe` out 1: 1 = pull PS2Data low, 0 = release.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse; byte sent and acknowledged.
- `ack_err` out 1: one-cycle pulse; device did not acknowledge.
- `timeout_err` out 1: one-cycle pulse; device stopped clocking.

## Operation
- Input synchronisation: `PS2Clk_in` and `PS2Data_in` each pass through 2 flip-flops. `fall` is a one-cycle strobe when the synchronised clock goes 1→0.
- Accept: `tx_valid && tx_ready` latches `tx_data` into `shreg` and sets `par = ~^tx_data` (odd parity).
- State machine:
  - **IDLE:** both oe = 0. Accept → INHIBIT.
  - **INHIBIT:** `ps2_clk_oe` = 1 for exactly INHIBIT_CYCLES cycles. In the last of those cycles, `ps2_data_oe` is also set to 1. → RTS.
  - **RTS:** `ps2_clk_oe` = 0, `ps2_data_oe` = 1. The timeout counter starts. → SHIFT.
  - **SHIFT:** on each `fall`, drive the next bit (low when the bit is 0):
    - falls 1–8: `shreg` LSB first;
    - fall 9: `par`;
    - fall 10: release data (stop bit);
    - → ACK.
  - **ACK:** on the next `fall`, sample the synchronised data. 0 → set `done`; 1 → set `ack_err`. → WAIT_IDLE.
  - **WAIT_IDLE:** wait until the synchronised clock and data are both 1 for 2 consecutive cycles. → IDLE. The `done`/`ack_err` pulse fires on the transition into IDLE.
- Timeout (`PS2_TX_TIMEOUT_EN` only): the counter runs through RTS, SHIFT and ACK and restarts on every `fall`. On reaching TIMEOUT_CYCLES:
  - release both lines in that cycle;
  - pulse `timeout_err`;
  - → IDLE directly.
- `tx_valid` in any non-IDLE state is ignored and does not queue.
- `tx_data` changes after accept do not affect the byte being sent.

## Timing
- Reset values: state IDLE, `tx_ready` = 1, all other outputs 0, counters 0.
- Reset asserted mid-transfer releases both lines on the first clock edge with `rst_n` = 0.
- Accept cycle N → `ps2_clk_oe` = 1 from cycle N+1 through N+INHIBIT_CYCLES. `ps2_data_oe` rises at N+INHIBIT_CYCLES. `ps2_clk_oe` falls at N+INHIBIT_CYCLES+1.
- Data output update: 3 cycles after the raw PS2Clk falling edge (2 synchroniser stages plus 1 register). The device samples on the rising edge, more than 30 µs later.
- Status outputs are exclusive: at most one of `done`, `ack_err`, `timeout_err` pulses per accepted byte. Exactly one pulses unless reset intervenes.
- A `fall` and the timeout terminal count in the same cycle: the `fall` wins and the counter restarts.
- `tx_ready` goes high in the same cycle as the completion pulse. Back-to-back accepts are therefore legal.

## Configuration
- `PS2_TX_TIMEOUT_EN` defined: timeout counter and `timeout_err` are present as described.
- Not defined: no counter is built, `timeout_err` is tied to 0, and the block waits indefinitely for device clocks. Only reset recovers a dead line.

## Structure
- Shared package `ps2_pkg`:
  - state enum (IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE);
  - command constants PS2_CMD_SET_LED = 8'hED, PS2_CMD_ENABLE = 8'hF4, PS2_CMD_RESET = 8'hFF;
  - PS2_ACK_BYTE = 8'hFA for the receive side.
- One sub-module, `ps2_line_sync`: 2-flip-flop synchroniser for both lines plus the falling-edge strobe, reusable by the receive path.

## Test plan
- Send 0xED with a device model that acknowledges → wire shows start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop released; ACK low; `done` pulses once; `tx_ready` high again.
- Send 0xF4 → parity bit 0; send 0xFF → parity bit 1; both end in `done`.
- Device holds data high at the ACK edge → `ack_err` pulses, no `done`, return to IDLE after the lines idle.
- With `PS2_TX_TIMEOUT_EN`, the device never clocks after RTS → `timeout_err` exactly TIMEOUT_CYCLES after RTS entry; both oe = 0.
- Assert `rst_n` = 0 after fall 4 → both oe = 0 on the next edge, `tx_ready` = 1 after release, and a new 0xED transfer completes normally.
- `tx_valid` held high with a changing `tx_data` → the second byte is accepted only in the cycle `tx_ready` rises after `done`; the first byte is unaffected.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, command bytes
// and the odd-parity helper used by host and receive paths.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_state_t;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for PS2Clk/PS2Data plus clock fall strobe.
// Ports: clk, rst_n (sync, active low), raw pins in; synced lines, fall out.
module ps2_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk_raw,
    input  logic ps2_data_raw,
    output logic ps2_clk_s,
    output logic ps2_data_s,
    output logic fall
);

    logic [1:0] clk_ff;
    logic [1:0] data_ff;
    logic       clk_d;

    // Reset to the idle (released, high) level so no false fall appears.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_ff  <= 2'b11;
            data_ff <= 2'b11;
            clk_d   <= 1'b1;
        end else begin
            clk_ff  <= {clk_ff[0], ps2_clk_raw};
            data_ff <= {data_ff[0], ps2_data_raw};
            clk_d   <= clk_ff[1];
        end
    end

    assign ps2_clk_s  = clk_ff[1];
    assign ps2_data_s = data_ff[1];
    assign fall       = clk_d & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter with open-drain line control.
// Ports: clk, rst_n (sync, active low); tx_data/tx_valid/tx_ready request;
// PS2Clk_in/PS2Data_in pins; ps2_clk_oe/ps2_data_oe pull-low enables;
// busy, done, ack_err, timeout_err status.
// Macro PS2_TX_TIMEOUT_EN builds the device-clock timeout counter.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       PS2Clk_in,
    input  logic       PS2Data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);

    ps2_state_t  state;
    logic [7:0]  shreg;
    logic        par;
    logic [3:0]  bit_cnt;
    logic [IW-1:0] inh_cnt;
    logic        ack_ok;
    logic        idle_seen;
    logic        clk_s;
    logic        data_s;
    logic        fall;
    logic        to_hit;

    ps2_line_sync u_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk_raw (PS2Clk_in),
        .ps2_data_raw(PS2Data_in),
        .ps2_clk_s   (clk_s),
        .ps2_data_s  (data_s),
        .fall        (fall)
    );

`ifdef PS2_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt;
    logic          to_live;

    assign to_live = state inside {RTS, SHIFT, ACK};
    // A device clock edge in the terminal cycle beats the timeout.
    assign to_hit  = to_live && !fall &&
                     (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || !to_live || fall || to_hit)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + TW'(1);
    end
`else
    // No counter: the parameter is kept so both builds share one interface.
    assign to_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            ack_err     <= 1'b0;
            timeout_err <= 1'b0;
            shreg       <= '0;
            par         <= 1'b0;
            bit_cnt     <= '0;
            inh_cnt     <= '0;
            ack_ok      <= 1'b0;
            idle_seen   <= 1'b0;
        end else begin
            done        <= 1'b0;
            ack_err     <= 1'b0;
            timeout_err <= 1'b0;
            if (to_hit) begin
                state       <= IDLE;
                tx_ready    <= 1'b1;
                busy        <= 1'b0;
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                timeout_err <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (tx_valid) begin
                            shreg       <= tx_data;
                            par         <= odd_parity(tx_data);
                            inh_cnt     <= '0;
                            bit_cnt     <= '0;
                            tx_ready    <= 1'b0;
                            busy        <= 1'b1;
                            ps2_clk_oe  <= 1'b1;
                            ps2_data_oe <= (INHIBIT_CYCLES == 1);
                            state       <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                            ps2_clk_oe  <= 1'b0;
                            ps2_data_oe <= 1'b1;
                            state       <= RTS;
                        end else begin
                            inh_cnt <= inh_cnt + IW'(1);
                            // Start bit goes low in the last hold cycle.
                            if (inh_cnt == IW'(INHIBIT_CYCLES - 2))
                                ps2_data_oe <= 1'b1;
                        end
                    end
                    RTS: begin
                        state <= SHIFT;
                    end
                    SHIFT: begin
                        if (fall) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            unique case (1'b1)
                                (bit_cnt < 4'd8): begin
                                    ps2_data_oe <= ~shreg[0];
                                    shreg       <= shreg >> 1;
                                end
                                (bit_cnt == 4'd8): begin
                                    ps2_data_oe <= ~par;
                                end
                                default: begin
                                    ps2_data_oe <= 1'b0;
                                    state       <= ACK;
                                end
                            endcase
                        end
                    end
                    ACK: begin
                        if (fall) begin
                            ack_ok    <= ~data_s;
                            idle_seen <= 1'b0;
                            state     <= WAIT_IDLE;
                        end
                    end
                    WAIT_IDLE: begin
                        if (clk_s && data_s) begin
                            if (idle_seen) begin
                                state    <= IDLE;
                                tx_ready <= 1'b1;
                                busy     <= 1'b0;
                                done     <= ack_ok;
                                ack_err  <= ~ack_ok;
                            end else begin
                                idle_seen <= 1'b1;
                            end
                        end else begin
                            idle_seen <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
